axis_accumulator: RTL and testbench
===================================

// Module: axis_accumulator
// PURPOSE
//   Integrate-and-dump stage. Sums cfg_data+1 consecutive input samples and emits
//   one sum per block, giving rate reduction with a boxcar response.
//   Sits directly upstream of axis_decimator in the ADC acquisition chain and feeds
//   it a reduced-rate, bit-grown stream.
// PARAMETERS
//   S_AXIS_TDATA_WIDTH  16  input sample width, two's complement when SIGNED=1
//   M_AXIS_TDATA_WIDTH  32  output sum width; must be >= S_AXIS_TDATA_WIDTH
//   CNTR_WIDTH          16  block-length counter width
//   SIGNED              1   1: sign-extend input; 0: zero-extend input
// PORTS
//   aclk           in   1                   clock; all logic is on the rising edge
//   areset         in   1                   synchronous reset, active-high
//   cfg_data       in   CNTR_WIDTH          block length minus one (N-1)
//   s_axis_tready  out  1                   input ready
//   s_axis_tdata   in   S_AXIS_TDATA_WIDTH  input sample
//   s_axis_tvalid  in   1                   input valid
//   m_axis_tready  in   1                   output ready
//   m_axis_tdata   out  M_AXIS_TDATA_WIDTH  block sum
//   m_axis_tvalid  out  1                   output valid
// BEHAVIOUR
//   - One clock (aclk). Reset is synchronous and active-high (areset).
//   - Reset values: acc=0, cntr=0, m_axis_tvalid=0, m_axis_tdata=0.
//     Reset mid-block discards the partial sum and any pending output.
//   - s_axis_tready = ~m_axis_tvalid | m_axis_tready.
//     This is a single output register with pass-through ready; there is no bubble
//     under continuous flow.
//   - Input handshake: s_axis_tvalid & s_axis_tready. Let x = the input extended to
//     M_AXIS_TDATA_WIDTH per SIGNED. On each handshake:
//       * cntr < cfg_data:  acc <= acc + x;  cntr <= cntr + 1
//       * cntr >= cfg_data (dump): m_axis_tdata <= acc + x;  m_axis_tvalid <= 1;
//         acc <= 0;  cntr <= 0
//   - Output handshake (m_axis_tvalid & m_axis_tready) with no dump in the same
//     cycle: m_axis_tvalid <= 0.
//   - Output handshake and dump in the same cycle: the register reloads with the new
//     sum and m_axis_tvalid stays 1.
//   - m_axis_tdata holds stable while m_axis_tvalid=1 and m_axis_tready=0.
//   - Latency: the sum appears 1 cycle after the handshake of the block's last sample.
//   - Arithmetic is modulo 2^M_AXIS_TDATA_WIDTH. Wrap is silent; no saturation.
//   - cfg_data=0: every sample is passed through extended, with 1-cycle latency.
//   - cfg_data is sampled live on each handshake, not latched per block. If it drops
//     to or below the current cntr, the next accepted sample dumps (>= compare). No
//     lockup and no counter wrap.
//   - With s_axis_tvalid=0 there is no state change apart from the output drain.
// STRUCTURE
//   - Shared package axis_accumulator_pkg:
//       * function ext(x, signed_en), which returns the extended sample
//       * localparam assertion M_AXIS_TDATA_WIDTH >= S_AXIS_TDATA_WIDTH
//   - Top level holds acc, cntr and the dump compare.
//   - One sub-module, axis_pipe_reg: a single-entry AXIS output register. It has
//     load/hold/drain and provides s_axis_tready = ~valid | m_axis_tready. It is
//     reusable by other stages.
// TESTING
//   1. cfg_data=3, SIGNED=1, inputs 1,2,3,4,-5,-6,-7,-8, m_axis_tready=1 ->
//      outputs 10 then -26, each 1 cycle after the 4th and 8th handshakes.
//   2. cfg_data=0, inputs 0x7FFF,0x8000 ->
//      outputs 0x00007FFF then 0xFFFF8000 (SIGNED=1); 0x00008000 with SIGNED=0.
//   3. cfg_data=1, continuous input, m_axis_tready low for 5 cycles after the first
//      sum -> s_axis_tready=0 while the register is full, no sample lost; sums
//      match the reference model.
//   4. cfg_data changed 7->2 when cntr=5 -> next accepted sample dumps the sum of
//      6 samples; the following blocks are 3 samples long.
//   5. areset asserted for 1 cycle mid-block with m_axis_tvalid=1 ->
//      next cycle m_axis_tvalid=0, acc=0; the next block sum excludes pre-reset data.
//   6. M=S=16, cfg_data=1, inputs 0x7FFF,0x0001 -> output 0x8000 (wrap, no saturate).

Source files
------------

// File: rtl/axis_accumulator_pkg.sv
// Shared types and helpers for the integrate-and-dump accumulator.
// Sample extension lives here so other AXIS stages can reuse it.
package axis_accumulator_pkg;

    localparam int unsigned MaxWidth = 64;

    // True when the output width can hold the extended input and fits the helper.
    function automatic bit width_ok(input int unsigned m_width, input int unsigned s_width);
        return (m_width >= s_width) && (m_width <= MaxWidth) && (s_width > 0);
    endfunction

    // Extends the low `width` bits of x to MaxWidth, sign- or zero-filled.
    function automatic logic [MaxWidth-1:0] ext(input logic [MaxWidth-1:0] x,
                                                input int unsigned      width,
                                                input logic             signed_en);
        logic [MaxWidth-1:0] r;
        logic [5:0]          msb;
        logic                fill;
        msb  = 6'(width - 1);
        fill = signed_en & x[msb];
        for (int unsigned i = 0; i < MaxWidth; i++) begin
            r[i] = (i < width) ? x[i] : fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream channel: data, valid, ready.
interface axis_if #(
    parameter int unsigned DataWidth = 16
);
    logic [DataWidth-1:0] tdata;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_pipe_reg.sv
// Single-entry AXIS output register with pass-through ready (no bubble under full flow).
module axis_pipe_reg #(
    parameter int unsigned Width = 32
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             load,
    input  logic [Width-1:0] load_data,
    output logic             in_ready,
    axis_if.master           m_axis
);

    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;

    assign in_ready = ~valid_q | m_axis.tready;

    // Load wins over drain so a dump coinciding with an output handshake keeps valid high.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (m_axis.tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign m_axis.tvalid = valid_q;
    assign m_axis.tdata  = data_q;

endmodule

// File: rtl/axis_accumulator.sv
// Integrate-and-dump: sums cfg_data+1 samples per block and emits one modulo-2^M sum.
module axis_accumulator
    import axis_accumulator_pkg::*;
#(
    parameter int unsigned S_AXIS_TDATA_WIDTH = 16,
    parameter int unsigned M_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned CNTR_WIDTH         = 16,
    parameter bit          SIGNED             = 1'b1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [CNTR_WIDTH-1:0] cfg_data,
    axis_if.slave                 s_axis,
    axis_if.master                m_axis
);

    if (!width_ok(M_AXIS_TDATA_WIDTH, S_AXIS_TDATA_WIDTH)) begin : g_width_err
        $error("axis_accumulator: M_AXIS_TDATA_WIDTH must be >= S_AXIS_TDATA_WIDTH");
    end

    logic [M_AXIS_TDATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNTR_WIDTH-1:0]         cntr_q, cntr_d;
    logic [M_AXIS_TDATA_WIDTH-1:0] sample_ext;
    logic [M_AXIS_TDATA_WIDTH-1:0] sum;
    logic                          in_ready;
    logic                          in_hs;
    logic                          dump;

    assign sample_ext = M_AXIS_TDATA_WIDTH'(ext(MaxWidth'(s_axis.tdata), S_AXIS_TDATA_WIDTH,
                                                SIGNED));
    assign sum        = acc_q + sample_ext;
    assign in_hs      = s_axis.tvalid & in_ready;
    // cfg_data is live; >= lets a shrunk block length dump immediately instead of wrapping.
    assign dump       = cntr_q >= cfg_data;

    always_comb begin
        acc_d  = acc_q;
        cntr_d = cntr_q;
        if (in_hs) begin
            if (dump) begin
                acc_d  = '0;
                cntr_d = '0;
            end else begin
                acc_d  = sum;
                cntr_d = cntr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_q  <= '0;
            cntr_q <= '0;
        end else begin
            acc_q  <= acc_d;
            cntr_q <= cntr_d;
        end
    end

    axis_pipe_reg #(
        .Width (M_AXIS_TDATA_WIDTH)
    ) u_out_reg (
        .aclk      (aclk),
        .areset    (areset),
        .load      (in_hs & dump),
        .load_data (sum),
        .in_ready  (in_ready),
        .m_axis    (m_axis)
    );

    assign s_axis.tready = in_ready;

endmodule

// File: tb/tb_axis_accumulator.sv
// Directed bench for axis_accumulator: signed/unsigned and narrow-output variants.
module tb_axis_accumulator;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] cfg_data;
    logic [15:0] in_data;
    logic        in_valid;
    logic        out_ready;

    int vectors     = 0;
    int miscompares = 0;
    int idx, k, stall;
    bit seen;
    int sums [5] = '{3, 7, 11, 15, 19};

    always #5 aclk = ~aclk;

    axis_if #(.DataWidth(16)) s_if ();
    axis_if #(.DataWidth(32)) m_if ();
    axis_if #(.DataWidth(16)) s_u ();
    axis_if #(.DataWidth(32)) m_u ();
    axis_if #(.DataWidth(16)) s_w ();
    axis_if #(.DataWidth(16)) m_w ();

    assign s_if.tdata  = in_data;
    assign s_if.tvalid = in_valid;
    assign m_if.tready = out_ready;
    assign s_u.tdata   = in_data;
    assign s_u.tvalid  = in_valid;
    assign m_u.tready  = out_ready;
    assign s_w.tdata   = in_data;
    assign s_w.tvalid  = in_valid;
    assign m_w.tready  = out_ready;

    axis_accumulator #(
        .S_AXIS_TDATA_WIDTH (16),
        .M_AXIS_TDATA_WIDTH (32),
        .CNTR_WIDTH         (16),
        .SIGNED             (1'b1)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .cfg_data (cfg_data),
        .s_axis   (s_if),
        .m_axis   (m_if)
    );

    axis_accumulator #(
        .S_AXIS_TDATA_WIDTH (16),
        .M_AXIS_TDATA_WIDTH (32),
        .CNTR_WIDTH         (16),
        .SIGNED             (1'b0)
    ) dut_u (
        .aclk     (aclk),
        .areset   (areset),
        .cfg_data (cfg_data),
        .s_axis   (s_u),
        .m_axis   (m_u)
    );

    axis_accumulator #(
        .S_AXIS_TDATA_WIDTH (16),
        .M_AXIS_TDATA_WIDTH (16),
        .CNTR_WIDTH         (16),
        .SIGNED             (1'b1)
    ) dut_w (
        .aclk     (aclk),
        .areset   (areset),
        .cfg_data (cfg_data),
        .s_axis   (s_w),
        .m_axis   (m_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input int d);
        in_data  = 16'(d);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        areset   = 1'b1;
        in_valid = 1'b0;
        tick();
        areset   = 1'b0;
    endtask

    initial begin
        areset    = 1'b1;
        cfg_data  = 16'd0;
        in_data   = 16'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        areset = 1'b0;

        check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("rst_tdata", m_if.tdata, 32'd0);
        check("rst_tready", 32'(s_if.tready), 32'd1);

        // Blocks of 4, signed: 1+2+3+4 = 10, -5-6-7-8 = -26
        cfg_data = 16'd3;
        send(1); send(2); send(3);
        check("t1_partial_tvalid", 32'(m_if.tvalid), 32'd0);
        send(4);
        check("t1_sum0_tvalid", 32'(m_if.tvalid), 32'd1);
        check("t1_sum0", m_if.tdata, 32'd10);
        send(-5);
        check("t1_drain_tvalid", 32'(m_if.tvalid), 32'd0);
        send(-6); send(-7); send(-8);
        check("t1_sum1", m_if.tdata, 32'hFFFF_FFE6);

        // Pass-through: signed vs unsigned extension
        do_reset();
        cfg_data = 16'd0;
        send(16'h7FFF);
        check("t2_pos_s", m_if.tdata, 32'h0000_7FFF);
        check("t2_pos_u", m_u.tdata, 32'h0000_7FFF);
        send(16'h8000);
        check("t2_neg_s", m_if.tdata, 32'hFFFF_8000);
        check("t2_neg_u", m_u.tdata, 32'h0000_8000);
        check("t2_reload_tvalid", 32'(m_u.tvalid), 32'd1);

        // 16-bit output wraps silently
        cfg_data = 16'd1;
        send(16'h7FFF);
        send(16'h0001);
        check("t6_wrap_tvalid", 32'(m_w.tvalid), 32'd1);
        check("t6_wrap", 32'(m_w.tdata), 32'h0000_8000);
        check("t6_wide", m_if.tdata, 32'h0000_8000);
        tick();
        check("t6_tready_u", 32'(s_u.tready), 32'd1);
        check("t6_tready_w", 32'(s_w.tready), 32'd1);

        // Continuous input 1..10, pairs, with 5 stalled cycles after the first sum
        do_reset();
        cfg_data = 16'd1;
        idx   = 0;
        k     = 0;
        stall = 0;
        seen  = 1'b0;
        for (int c = 0; c < 40 && k < 5; c++) begin
            in_valid = (idx < 10);
            in_data  = 16'(idx + 1);
            if (stall > 0) begin
                out_ready = 1'b0;
                stall--;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge aclk);
            if (m_if.tvalid && !out_ready) begin
                check("t3_full_tready", 32'(s_if.tready), 32'd0);
            end
            if (m_if.tvalid && out_ready) begin
                check($sformatf("t3_sum%0d", k), m_if.tdata, 32'(sums[k]));
                k++;
                if (!seen) begin
                    seen  = 1'b1;
                    stall = 5;
                end
            end
            if (in_valid && s_if.tready) idx++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t3_nsums", 32'(k), 32'd5);
        check("t3_ninputs", 32'(idx), 32'd10);

        // Block length shrinks 8 -> 3 while cntr = 5
        do_reset();
        cfg_data = 16'd7;
        send(1); send(2); send(3); send(4); send(5);
        cfg_data = 16'd2;
        send(6);
        check("t4_early_tvalid", 32'(m_if.tvalid), 32'd1);
        check("t4_early_sum", m_if.tdata, 32'd21);
        send(7);
        check("t4_mid_tvalid", 32'(m_if.tvalid), 32'd0);
        send(8); send(9);
        check("t4_blk3_a", m_if.tdata, 32'd24);
        send(10); send(11); send(12);
        check("t4_blk3_b", m_if.tdata, 32'd33);

        // Reset with a pending output, then reset mid-block
        do_reset();
        cfg_data = 16'd3;
        send(1); send(2); send(3); send(4);
        check("t5_pending_tvalid", 32'(m_if.tvalid), 32'd1);
        out_ready = 1'b0;
        do_reset();
        check("t5_rst_tvalid", 32'(m_if.tvalid), 32'd0);
        check("t5_rst_tdata", m_if.tdata, 32'd0);
        out_ready = 1'b1;
        send(5); send(6);
        do_reset();
        send(10); send(20); send(30);
        check("t5_partial_tvalid", 32'(m_if.tvalid), 32'd0);
        send(40);
        check("t5_clean_sum", m_if.tdata, 32'd100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
